// File: rtl/pvt_host_cmd_master.sv
// Host-side command initiator for the PVT sensor UART protocol: serialises
// group/type/payload bytes onto a TX byte stream and collects 4-byte read results.
module pvt_host_cmd_master #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_PAYLOAD    = 12
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [7:0]               cmd_group,
  input  logic [3:0]               cmd_type,
  input  logic [3:0]               cmd_len,
  input  logic [8*MAX_PAYLOAD-1:0] cmd_payload,
  input  logic                     cmd_expect_rsp,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [7:0]               tx_data,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     cmd_done,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_data,
  output logic                     rsp_timeout,
  output logic                     rx_drop
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_GRP,
    ST_SEND_TYPE,
    ST_SEND_PAY,
    ST_WAIT_RSP
  } state_e;

  state_e           state_q;
  logic [3:0]       type_q;
  logic [3:0]       len_q;
  logic             expect_q;
  logic [7:0]       pay_q [MAX_PAYLOAD];
  logic [3:0]       pay_idx_q;
  logic [1:0]       rx_idx_q;
  logic [23:0]      shift_q;
  logic [CNT_W-1:0] tmo_cnt_q;

  logic             cmd_ready_q;
  logic             tx_valid_q;
  logic [7:0]       tx_data_q;
  logic             cmd_done_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_data_q;
  logic             rsp_timeout_q;
  logic             rx_drop_q;

  logic [3:0]       len_d;
  logic [3:0]       pay_nxt;
  logic             tx_fire;
  logic             last_tx;
  logic             tmo_expire;

  // Oversized lengths are clamped rather than rejected so the frame stays well-formed.
  assign len_d   = (int'(cmd_len) > MAX_PAYLOAD) ? 4'(MAX_PAYLOAD) : cmd_len;
  assign pay_nxt = pay_idx_q + 4'd1;
  assign tx_fire = tx_valid_q && tx_ready;
  assign last_tx = tx_fire &&
                   (((state_q == ST_SEND_TYPE) && (len_q == 4'd0)) ||
                    ((state_q == ST_SEND_PAY) && (pay_nxt == len_q)));
  assign tmo_expire = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      type_q        <= '0;
      len_q         <= '0;
      expect_q      <= 1'b0;
      for (int k = 0; k < MAX_PAYLOAD; k++) pay_q[k] <= '0;
      pay_idx_q     <= '0;
      rx_idx_q      <= '0;
      shift_q       <= '0;
      tmo_cnt_q     <= '0;
      cmd_ready_q   <= 1'b1;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      cmd_done_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      rx_drop_q     <= 1'b0;
    end else begin
      cmd_done_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rx_drop_q   <= rx_valid && (state_q != ST_WAIT_RSP);

      if (last_tx) begin
        tx_valid_q <= 1'b0;
        if (expect_q) begin
          state_q   <= ST_WAIT_RSP;
          tmo_cnt_q <= '0;
          rx_idx_q  <= '0;
        end else begin
          state_q     <= ST_IDLE;
          cmd_done_q  <= 1'b1;
          cmd_ready_q <= 1'b1;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
              type_q      <= cmd_type;
              len_q       <= len_d;
              expect_q    <= cmd_expect_rsp;
              for (int k = 0; k < MAX_PAYLOAD; k++) pay_q[k] <= cmd_payload[8*k +: 8];
              cmd_ready_q <= 1'b0;
              tx_valid_q  <= 1'b1;
              tx_data_q   <= cmd_group;
              state_q     <= ST_SEND_GRP;
            end
          end
          ST_SEND_GRP: begin
            if (tx_fire) begin
              tx_data_q <= {4'b0000, type_q};
              state_q   <= ST_SEND_TYPE;
            end
          end
          ST_SEND_TYPE: begin
            if (tx_fire) begin
              tx_data_q <= pay_q[0];
              pay_idx_q <= '0;
              state_q   <= ST_SEND_PAY;
            end
          end
          ST_SEND_PAY: begin
            if (tx_fire) begin
              tx_data_q <= pay_q[pay_nxt];
              pay_idx_q <= pay_nxt;
            end
          end
          ST_WAIT_RSP: begin
            // A byte arriving in the expiry cycle takes priority over the timeout.
            if (rx_valid) begin
              tmo_cnt_q <= '0;
              if (rx_idx_q == 2'd3) begin
                rsp_data_q    <= {rx_data, shift_q};
                rsp_valid_q   <= 1'b1;
                rsp_timeout_q <= 1'b0;
                cmd_done_q    <= 1'b1;
                cmd_ready_q   <= 1'b1;
                rx_idx_q      <= '0;
                state_q       <= ST_IDLE;
              end else begin
                case (rx_idx_q)
                  2'd0:    shift_q[7:0]   <= rx_data;
                  2'd1:    shift_q[15:8]  <= rx_data;
                  default: shift_q[23:16] <= rx_data;
                endcase
                rx_idx_q <= rx_idx_q + 2'd1;
              end
            end else if (tmo_expire) begin
              rsp_data_q    <= '0;
              rsp_valid_q   <= 1'b1;
              rsp_timeout_q <= 1'b1;
              cmd_done_q    <= 1'b1;
              cmd_ready_q   <= 1'b1;
              rx_idx_q      <= '0;
              tmo_cnt_q     <= '0;
              state_q       <= ST_IDLE;
            end else begin
              tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            tx_valid_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign cmd_done    = cmd_done_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rx_drop     = rx_drop_q;

endmodule

// File: tb/tb_pvt_host_cmd_master.sv
// Directed bench for pvt_host_cmd_master: frame serialisation, stalls, read
// responses, timeout, stray rx bytes, length clamp and mid-frame reset.
module tb_pvt_host_cmd_master;

  localparam int MAXP = 12;
  localparam int TMO  = 16;

  logic              clk;
  logic              rstn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_group;
  logic [3:0]        cmd_type;
  logic [3:0]        cmd_len;
  logic [8*MAXP-1:0] cmd_payload;
  logic              cmd_expect_rsp;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        tx_data;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              cmd_done;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_timeout;
  logic              rx_drop;

  int checks;
  int failures;

  pvt_host_cmd_master #(.TIMEOUT_CYCLES(TMO), .MAX_PAYLOAD(MAXP)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_group(cmd_group), .cmd_type(cmd_type), .cmd_len(cmd_len),
    .cmd_payload(cmd_payload), .cmd_expect_rsp(cmd_expect_rsp),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .cmd_done(cmd_done), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .rx_drop(rx_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [7:0] grp, input logic [3:0] typ, input logic [3:0] len,
                           input logic [8*MAXP-1:0] pay, input logic exp_rsp);
    cmd_group      = grp;
    cmd_type       = typ;
    cmd_len        = len;
    cmd_payload    = pay;
    cmd_expect_rsp = exp_rsp;
    cmd_valid      = 1'b1;
    tick();
    cmd_valid      = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    cmd_valid = 1'b0; cmd_group = '0; cmd_type = '0; cmd_len = '0;
    cmd_payload = '0; cmd_expect_rsp = 1'b0; tx_ready = 1'b0;
    rx_valid = 1'b0; rx_data = '0;
    repeat (3) tick();
    checks++;
    if (cmd_ready !== 1'b1 || tx_valid !== 1'b0 || tx_data !== 8'h00 || cmd_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl: got ready=%b txv=%b txd=%h done=%b, want 1 0 00 0",
               cmd_ready, tx_valid, tx_data, cmd_done);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_timeout !== 1'b0 || rx_drop !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp: got rv=%b rd=%h rt=%b drop=%b, want 0 00000000 0 0",
               rsp_valid, rsp_data, rsp_timeout, rx_drop);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_enable();
    logic [7:0] exp_b [3];
    logic [8*MAXP-1:0] pay;
    exp_b[0] = 8'h03; exp_b[1] = 8'h00; exp_b[2] = 8'h01;
    pay = '0;
    pay[7:0] = 8'h01;
    tx_ready = 1'b1;
    issue_cmd(8'h03, 4'h0, 4'd1, pay, 1'b0);
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL enable_busy: got cmd_ready=%b, want 0", cmd_ready);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_b[i] || cmd_done !== 1'b0) begin
        failures++;
        $display("FAIL enable_byte%0d: got txv=%b txd=%h done=%b, want 1 %h 0",
                 i, tx_valid, tx_data, cmd_done, exp_b[i]);
      end
      tick();
    end
    checks++;
    if (cmd_done !== 1'b1 || tx_valid !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL enable_done: got done=%b txv=%b rv=%b ready=%b, want 1 0 0 1",
               cmd_done, tx_valid, rsp_valid, cmd_ready);
    end
    tick();
    checks++;
    if (cmd_done !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL enable_pulse: got done=%b rv=%b, want 0 0", cmd_done, rsp_valid);
    end
  endtask

  task automatic test_coef_write();
    logic [7:0] exp_b [14];
    logic [8*MAXP-1:0] pay;
    int idx;
    int cyc;
    exp_b[0] = 8'h03; exp_b[1] = 8'h02;
    for (int k = 0; k < 12; k++) begin
      pay[8*k +: 8] = 8'(k + 1);
      exp_b[k + 2]  = 8'(k + 1);
    end
    tx_ready = 1'b1;
    issue_cmd(8'h03, 4'h2, 4'd12, pay, 1'b0);
    idx = 0;
    cyc = 0;
    while (idx < 14 && cyc < 100) begin
      tx_ready = (cyc % 2 == 0);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_b[idx]) begin
        failures++;
        $display("FAIL coef_byte%0d cyc%0d: got txv=%b txd=%h, want 1 %h",
                 idx, cyc, tx_valid, tx_data, exp_b[idx]);
      end
      if (tx_ready) idx++;
      tick();
      cyc++;
    end
    tx_ready = 1'b1;
    checks++;
    if (idx != 14 || cmd_done !== 1'b1 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL coef_done: got bytes=%0d done=%b txv=%b, want 14 1 0", idx, cmd_done, tx_valid);
    end
    tick();
  endtask

  task automatic run_read(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [31:0] want, input string tag);
    logic [7:0] rb [4];
    rb[0] = b0; rb[1] = b1; rb[2] = b2; rb[3] = b3;
    tx_ready = 1'b1;
    issue_cmd(8'h03, 4'h3, 4'd0, '0, 1'b1);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h03) begin
      failures++;
      $display("FAIL %s_grp: got txv=%b txd=%h, want 1 03", tag, tx_valid, tx_data);
    end
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h03) begin
      failures++;
      $display("FAIL %s_type: got txv=%b txd=%h, want 1 03", tag, tx_valid, tx_data);
    end
    tick();
    tick();
    checks++;
    if (tx_valid !== 1'b0 || cmd_done !== 1'b0 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_wait: got txv=%b done=%b ready=%b, want 0 0 0", tag, tx_valid, cmd_done, cmd_ready);
    end
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1;
      rx_data  = rb[i];
      tick();
      rx_valid = 1'b0;
      if (i < 3) begin
        checks++;
        if (rsp_valid !== 1'b0) begin
          failures++;
          $display("FAIL %s_early%0d: got rsp_valid=%b, want 0", tag, i, rsp_valid);
        end
        tick();
      end
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== want || rsp_timeout !== 1'b0 || cmd_done !== 1'b1) begin
      failures++;
      $display("FAIL %s_rsp: got rv=%b rd=%h rt=%b done=%b, want 1 %h 0 1",
               tag, rsp_valid, rsp_data, rsp_timeout, cmd_done, want);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== want || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_hold: got rv=%b rd=%h ready=%b, want 0 %h 1", tag, rsp_valid, rsp_data, cmd_ready, want);
    end
  endtask

  task automatic test_read();
    run_read(8'h78, 8'h56, 8'h34, 8'h12, 32'h12345678, "read");
  endtask

  task automatic test_timeout();
    int k;
    tx_ready = 1'b1;
    issue_cmd(8'h03, 4'h3, 4'd0, '0, 1'b1);
    repeat (2) tick();
    rx_valid = 1'b1; rx_data = 8'hAA;
    tick();
    rx_data = 8'hBB;
    tick();
    rx_valid = 1'b0;
    k = 0;
    while (k < 40 && rsp_valid !== 1'b1) begin
      tick();
      k++;
    end
    checks++;
    if (k != TMO || rsp_timeout !== 1'b1 || rsp_data !== 32'h0 || cmd_done !== 1'b1) begin
      failures++;
      $display("FAIL timeout_rsp: got after=%0d rt=%b rd=%h done=%b, want %0d 1 00000000 1",
               k, rsp_timeout, rsp_data, cmd_done, TMO);
    end
    tick();
    run_read(8'h44, 8'h33, 8'h22, 8'h11, 32'h11223344, "post_tmo");
    checks++;
    if (rsp_timeout !== 1'b0) begin
      failures++;
      $display("FAIL post_tmo_flag: got rsp_timeout=%b, want 0", rsp_timeout);
    end
  endtask

  task automatic test_stray_and_clamp();
    logic [8*MAXP-1:0] pay;
    int n;
    int cyc;
    rx_valid = 1'b1; rx_data = 8'h5A;
    tick();
    rx_valid = 1'b0;
    checks++;
    if (rx_drop !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL stray_drop: got drop=%b rv=%b, want 1 0", rx_drop, rsp_valid);
    end
    tick();
    checks++;
    if (rx_drop !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL stray_pulse: got drop=%b rv=%b, want 0 0", rx_drop, rsp_valid);
    end
    for (int b = 0; b < MAXP; b++) pay[8*b +: 8] = 8'(8'h10 + b);
    tx_ready = 1'b1;
    issue_cmd(8'h07, 4'h1, 4'd15, pay, 1'b0);
    n = 0;
    cyc = 0;
    while (cmd_done !== 1'b1 && cyc < 40) begin
      if (tx_valid === 1'b1) begin
        if (n >= 2) begin
          checks++;
          if (tx_data !== 8'(8'h10 + n - 2)) begin
            failures++;
            $display("FAIL clamp_byte%0d: got %h, want %h", n - 2, tx_data, 8'(8'h10 + n - 2));
          end
        end
        n++;
      end
      tick();
      cyc++;
    end
    checks++;
    if (n != 14 || cmd_done !== 1'b1) begin
      failures++;
      $display("FAIL clamp_count: got bytes=%0d done=%b, want 14 1", n, cmd_done);
    end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    logic [8*MAXP-1:0] pay;
    for (int b = 0; b < MAXP; b++) pay[8*b +: 8] = 8'(8'hA0 + b);
    tx_ready = 1'b1;
    issue_cmd(8'h03, 4'h2, 4'd12, pay, 1'b0);
    repeat (5) tick();
    checks++;
    if (tx_valid !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre: got tx_valid=%b, want 1", tx_valid);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_async: got txv=%b ready=%b, want 0 1", tx_valid, cmd_ready);
    end
    tick();
    rstn = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || tx_valid !== 1'b0 || cmd_done !== 1'b0) begin
      failures++;
      $display("FAIL midrst_release: got ready=%b txv=%b done=%b, want 1 0 0", cmd_ready, tx_valid, cmd_done);
    end
    issue_cmd(8'h55, 4'h0, 4'd0, '0, 1'b0);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h55) begin
      failures++;
      $display("FAIL midrst_restart: got txv=%b txd=%h, want 1 55", tx_valid, tx_data);
    end
    repeat (3) tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_enable();
    test_coef_write();
    test_read();
    test_timeout();
    test_stray_and_clamp();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
